rom_sram_responder: RTL and testbench

- Memory-side responder for the PC/ROM request bus. It accepts the fetch-or-access request (pc_or_addr, ce, rom_op, rom_wr_data) and executes it as a multi-cycle access on the board's 32-bit asynchronous base SRAM.
- It returns read data and holds the pipeline with a stall request until the access completes.
- It sits between the PC stage and the top-level SRAM pins; the tri-state pad is instantiated in the top wrapper.

---
 rtl/rom_sram_responder_pkg.sv | 23 ++
 rtl/rom_sram_responder.sv | 137 +++++++++++++
 tb/tb_rom_sram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_sram_responder_pkg.sv
// Shared definitions for the PC/ROM bus to base-SRAM responder.
//   ROM_READ / ROM_WRITE : request opcode values on rom_op_i
//   sram_state_e         : 3-bit responder state encoding
//   max_u                : constant helper for sizing the wait counter
package rom_sram_responder_pkg;

  localparam logic ROM_READ  = 1'b0;
  localparam logic ROM_WRITE = 1'b1;

  typedef enum logic [2:0] {
    SRAM_IDLE     = 3'd0,
    SRAM_RD       = 3'd1,
    SRAM_WR_SETUP = 3'd2,
    SRAM_WR_PULSE = 3'd3,
    SRAM_WR_HOLD  = 3'd4,
    SRAM_DONE     = 3'd5
  } sram_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rom_sram_responder.sv
// Memory-side responder for the PC/ROM request bus. Runs each accepted
// request as a multi-cycle word access on the 32-bit asynchronous base SRAM
// and holds the pipeline via stall_req_o until the access completes.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ce_i, rom_op_i      request valid; 0 = read, 1 = write
//   addr_i, wr_data_i   byte address and write data (held while stalled)
//   rd_data_o           read data, valid in the DONE cycle
//   stall_req_o         high while the request is not complete
//   sram_addr_o         SRAM word address (addr_i[21:2])
//   sram_data_o/_oe_o   write data and pad driver enable
//   sram_data_i         read data from the pad
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o  SRAM strobes (active low)
module rom_sram_responder
  import rom_sram_responder_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned READ_WAIT   = 2,
  parameter int unsigned WE_PULSE    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic                   rom_op_i,
  input  logic [31:0]            addr_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic                   stall_req_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0]      sram_data_o,
  output logic                   sram_data_oe_o,
  input  logic [DATA_W-1:0]      sram_data_i,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [3:0]             sram_be_n_o
);

  localparam int unsigned CNT_W = $clog2(max_u(READ_WAIT, WE_PULSE) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_PULSE - 1);

  sram_state_e      state;
  logic [CNT_W-1:0] cnt;

  // Byte-lane and high address bits are deliberately ignored (word access only).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:SRAM_ADDR_W+2], addr_i[1:0]};

  // Combinational so the requester sees the stall in the acceptance cycle.
  assign stall_req_o = rst &&
                       (((state == SRAM_IDLE) && ce_i) ||
                        ((state != SRAM_IDLE) && (state != SRAM_DONE)));

  // Outputs are registered, so each branch programs the strobes of the state
  // being entered on this edge, not the one being left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= SRAM_IDLE;
      cnt            <= '0;
      rd_data_o      <= '0;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= '1;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (ce_i) begin
            sram_addr_o <= addr_i[SRAM_ADDR_W+1:2];
            sram_ce_n_o <= 1'b0;
            sram_be_n_o <= '0;
            if (rom_op_i == ROM_WRITE) begin
              state          <= SRAM_WR_SETUP;
              sram_data_o    <= wr_data_i;
              sram_data_oe_o <= 1'b1;
              cnt            <= '0;
            end else begin
              state       <= SRAM_RD;
              sram_oe_n_o <= 1'b0;
              cnt         <= RD_LOAD;
            end
          end
        end
        SRAM_RD: begin
          if (cnt == '0) begin
            rd_data_o   <= sram_data_i;
            state       <= SRAM_DONE;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_be_n_o <= '1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SRAM_WR_SETUP: begin
          state       <= SRAM_WR_PULSE;
          sram_we_n_o <= 1'b0;
          cnt         <= WE_LOAD;
        end
        SRAM_WR_PULSE: begin
          if (cnt == '0) begin
            state       <= SRAM_WR_HOLD;
            sram_we_n_o <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SRAM_WR_HOLD: begin
          state          <= SRAM_DONE;
          sram_ce_n_o    <= 1'b1;
          sram_data_oe_o <= 1'b0;
          sram_be_n_o    <= '1;
        end
        SRAM_DONE: begin
          state <= SRAM_IDLE;
          cnt   <= '0;
        end
        default: begin
          state          <= SRAM_IDLE;
          cnt            <= '0;
          sram_data_oe_o <= 1'b0;
          sram_ce_n_o    <= 1'b1;
          sram_oe_n_o    <= 1'b1;
          sram_we_n_o    <= 1'b1;
          sram_be_n_o    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sram_responder.sv
// Directed bench for rom_sram_responder with a behavioural asynchronous SRAM.
module tb_rom_sram_responder;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_dout;
  logic        sram_oe;
  logic [31:0] sram_din;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic [3:0]  be_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<20)-1];

  rom_sram_responder #(
    .SRAM_ADDR_W(20),
    .DATA_W     (32),
    .READ_WAIT  (2),
    .WE_PULSE   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce),
    .rom_op_i      (op),
    .addr_i        (addr),
    .wr_data_i     (wdata),
    .rd_data_o     (rd_data),
    .stall_req_o   (stall),
    .sram_addr_o   (sram_addr),
    .sram_data_o   (sram_dout),
    .sram_data_oe_o(sram_oe),
    .sram_data_i   (sram_din),
    .sram_ce_n_o   (ce_n),
    .sram_oe_n_o   (oe_n),
    .sram_we_n_o   (we_n),
    .sram_be_n_o   (be_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Asynchronous SRAM: combinational read, write committed on rising WE.
  always @* begin
    if (!ce_n && !oe_n) sram_din = mem[sram_addr];
    else                sram_din = 32'h0;
  end

  always @(posedge we_n) begin
    if (!ce_n && sram_oe) mem[sram_addr] = sram_dout;
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      assert (!(sram_oe && !oe_n))
      else begin
        errors++;
        $display("FAIL contention: oe=%b oe_n=%b required not both active", sram_oe, oe_n);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request at a negedge and observe it until the DONE cycle.
  task automatic run_access(input logic a_op, input logic [31:0] a_addr,
                            input logic [31:0] a_wd, input logic [19:0] exp_addr,
                            output int pre, output int stalls, output int we_low,
                            output int oe_cyc, output logic addr_ok, output logic data_ok);
    bit seen = 0;
    int n = 0;
    pre = 0; stalls = 0; we_low = 0; oe_cyc = 0; addr_ok = 1'b1; data_ok = 1'b1;
    ce = 1'b1; op = a_op; addr = a_addr; wdata = a_wd;
    #1;
    while (!(seen && !stall) && n < 60) begin
      if (stall) begin seen = 1; stalls++; end
      else pre++;
      if (!we_n) we_low++;
      if (sram_oe) begin
        oe_cyc++;
        if (sram_dout !== a_wd) data_ok = 1'b0;
      end
      if (!ce_n && (sram_addr !== exp_addr || be_n !== 4'h0)) addr_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 60) stalls = -1;
  endtask

  task automatic release_bus();
    ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1; op = 1'b0; addr = 32'h100; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b required 111", {ce_n, oe_n, we_n});
    end
    checks++;
    if (be_n !== 4'hF || sram_oe !== 1'b0) begin
      errors++; $display("FAIL reset_be_oe: be_n=%h oe=%b required F 0", be_n, sram_oe);
    end
    checks++;
    if (stall !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_stall_rd: stall=%b rd=%h required 0 0", stall, rd_data);
    end
    ce = 1'b0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int pre, st, wl, oc; logic aok, dok;
    run_access(1'b0, 32'h0000_0100, 32'h0, 20'h00040, pre, st, wl, oc, aok, dok);
    checks++;
    if (st !== 3) begin errors++; $display("FAIL read_stalls: got %0d required 3", st); end
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h required deadbeef", rd_data);
    end
    checks++;
    if (!aok || oc != 0 || wl != 0) begin
      errors++; $display("FAIL read_bus: addr_ok=%b oe_cycles=%0d we_low=%0d required 1 0 0", aok, oc, wl);
    end
  endtask

  task automatic test_write_readback();
    int pre, st, wl, oc; logic aok, dok;
    run_access(1'b1, 32'h0000_0FFC, 32'h12345678, 20'h003FF, pre, st, wl, oc, aok, dok);
    checks++;
    if (st !== 5) begin errors++; $display("FAIL write_stalls: got %0d required 5", st); end
    checks++;
    if (wl !== 2) begin errors++; $display("FAIL write_we_low: got %0d required 2", wl); end
    checks++;
    if (oc !== 4 || !dok) begin
      errors++; $display("FAIL write_data_drive: oe_cycles=%0d data_ok=%b required 4 1", oc, dok);
    end
    checks++;
    if (rd_data !== 32'hDEADBEEF || !aok) begin
      errors++; $display("FAIL write_rd_hold: rd=%h addr_ok=%b required deadbeef 1", rd_data, aok);
    end
    // Read-back issued while the write is still in DONE.
    run_access(1'b0, 32'h0000_0FFC, 32'h0, 20'h003FF, pre, st, wl, oc, aok, dok);
    checks++;
    if (pre !== 1 || st !== 3) begin
      errors++; $display("FAIL readback_timing: bubble=%0d stalls=%0d required 1 3", pre, st);
    end
    checks++;
    if (rd_data !== 32'h12345678) begin
      errors++; $display("FAIL readback_data: got %h required 12345678", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int pre, st, wl, oc; logic aok, dok;
    run_access(1'b0, 32'h0000_0000, 32'h0, 20'h00000, pre, st, wl, oc, aok, dok);
    checks++;
    if (rd_data !== 32'hA5A50000 || st !== 3 || !aok) begin
      errors++; $display("FAIL b2b_first: rd=%h stalls=%0d addr_ok=%b required a5a50000 3 1", rd_data, st, aok);
    end
    run_access(1'b0, 32'h0000_0004, 32'h0, 20'h00001, pre, st, wl, oc, aok, dok);
    checks++;
    if (pre !== 1 || st !== 3) begin
      errors++; $display("FAIL b2b_second_timing: bubble=%0d stalls=%0d required 1 3", pre, st);
    end
    checks++;
    if (rd_data !== 32'h00005A5A || !aok) begin
      errors++; $display("FAIL b2b_second_data: rd=%h addr_ok=%b required 00005a5a 1", rd_data, aok);
    end
  endtask

  task automatic test_reset_mid_write();
    int pre, st, wl, oc; logic aok, dok;
    int n = 0;
    ce = 1'b1; op = 1'b1; addr = 32'h0000_0200; wdata = 32'hCAFEF00D;
    @(negedge clk);
    while (we_n !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (we_n !== 1'b0) begin errors++; $display("FAIL midrst_pulse_seen: we_n=%b required 0", we_n); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ce_n, we_n, sram_oe, stall} !== 4'b1100) begin
      errors++; $display("FAIL midrst_async: ce_n,we_n,oe,stall=%b required 1100", {ce_n, we_n, sram_oe, stall});
    end
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_access(1'b0, 32'h0000_0100, 32'h0, 20'h00040, pre, st, wl, oc, aok, dok);
    checks++;
    if (rd_data !== 32'hDEADBEEF || st !== 3 || pre !== 0) begin
      errors++; $display("FAIL midrst_recover: rd=%h stalls=%0d bubble=%0d required deadbeef 3 0", rd_data, st, pre);
    end
  endtask

  task automatic test_random_addr();
    int pre, st, wl, oc; logic aok, dok;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = $urandom | 32'hFFC0_0003;
      a[21:2] = 20'($urandom_range(20'hFFFFF, 20'h01000));
      d = $urandom;
      run_access(1'b1, a, d, a[21:2], pre, st, wl, oc, aok, dok);
      checks++;
      if (!aok || !dok || st !== 5) begin
        errors++; $display("FAIL rand_write%0d: addr=%h addr_ok=%b data_ok=%b stalls=%0d required 1 1 5", i, a, aok, dok, st);
      end
      run_access(1'b0, a, 32'h0, a[21:2], pre, st, wl, oc, aok, dok);
      checks++;
      if (!aok || rd_data !== d) begin
        errors++; $display("FAIL rand_read%0d: addr=%h rd=%h addr_ok=%b required %h 1", i, a, rd_data, aok, d);
      end
      release_bus();
    end
  endtask

  initial begin
    mem[20'h00040] = 32'hDEADBEEF;
    mem[20'h00000] = 32'hA5A50000;
    mem[20'h00001] = 32'h00005A5A;
    test_reset();
    test_read();
    release_bus();
    test_write_readback();
    release_bus();
    test_back_to_back();
    release_bus();
    test_reset_mid_write();
    release_bus();
    test_random_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
